// File: rtl/tetris_pkg.sv
// Shared encodings and helpers for the move scheduler: command codes, FSM states,
// gravity period lookup and the fixed command priority.
package tetris_pkg;

    typedef enum logic [2:0] {
        MOVE_CW    = 3'b000,
        MOVE_CCW   = 3'b001,
        MOVE_DOWN  = 3'b010,
        MOVE_LEFT  = 3'b011,
        MOVE_RIGHT = 3'b100,
        MOVE_NONE  = 3'b101
    } move_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_NEXT  = 2'd2
    } sched_state_e;

    // Pending-bit vectors are indexed by the command code.
    localparam int NUM_MOVES  = 5;
    localparam int PERIOD_W   = 8;
    localparam int DAS_FRAMES = 10;
    localparam int ARR_FRAMES = 3;
    localparam int REPEAT_W   = 4;

    function automatic logic [PERIOD_W-1:0] period_of(
        input logic [1:0]  velocity,
        input int unsigned p0,
        input int unsigned p1,
        input int unsigned p2,
        input int unsigned p3
    );
        logic [PERIOD_W-1:0] period;
        case (velocity)
            2'b00:   period = PERIOD_W'(p0);
            2'b01:   period = PERIOD_W'(p1);
            2'b10:   period = PERIOD_W'(p2);
            default: period = PERIOD_W'(p3);
        endcase
        return period;
    endfunction

    function automatic move_e pick_winner(input logic [NUM_MOVES-1:0] pend);
        move_e win;
        if (pend[0])      win = MOVE_CW;
        else if (pend[1]) win = MOVE_CCW;
        else if (pend[3]) win = MOVE_LEFT;
        else if (pend[4]) win = MOVE_RIGHT;
        else if (pend[2]) win = MOVE_DOWN;
        else              win = MOVE_NONE;
        return win;
    endfunction

endpackage

// File: rtl/gravity_timer.sv
// Counts frame_start pulses and emits a one-cycle tick when the gravity period
// for the current velocity elapses; clear/freeze return the count to zero.
module gravity_timer
    import tetris_pkg::*;
#(
    parameter int unsigned PERIOD_V0 = 48,
    parameter int unsigned PERIOD_V1 = 24,
    parameter int unsigned PERIOD_V2 = 12,
    parameter int unsigned PERIOD_V3 = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic [1:0] velocity,
    input  logic       clear,
    input  logic       freeze,
    output logic       tick
);

    logic [PERIOD_W-1:0] count_q;
    logic [PERIOD_W-1:0] count_d;
    logic [PERIOD_W-1:0] count_inc;
    logic [PERIOD_W-1:0] period;

    assign period    = period_of(velocity, PERIOD_V0, PERIOD_V1, PERIOD_V2, PERIOD_V3);
    assign count_inc = count_q + PERIOD_W'(1);

    // '>=' rather than '==' so a drop to a shorter period fires on the next frame.
    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (freeze || clear) begin
            count_d = '0;
        end else if (frame_start) begin
            if (count_inc >= period) begin
                tick    = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/move_scheduler.sv
// Turns button edges and gravity ticks into one-at-a-time move commands, dispatched
// only in the window opened by frame_start. Optional hold-to-repeat: AUTO_REPEAT_EN.
module move_scheduler
    import tetris_pkg::*;
#(
    parameter int unsigned PERIOD_V0     = 48,
    parameter int unsigned PERIOD_V1     = 24,
    parameter int unsigned PERIOD_V2     = 12,
    parameter int unsigned PERIOD_V3     = 6,
    parameter int unsigned MAX_PER_FRAME = 2,
    parameter int unsigned ACK_TIMEOUT   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_cw,
    input  logic       btn_ccw,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic [1:0] velocity,
    input  logic       frame_start,
    input  logic       game_over,
    input  logic       move_ack,
    output logic       move_valid,
    output logic [2:0] move_cmd,
    output logic       timeout_err
);

    localparam int WAIT_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int ISSUED_W = 3;

    sched_state_e state_q, state_d;
    move_e        cmd_q, cmd_d, winner;

    logic [NUM_MOVES-1:0] btn_now, btn_prev_q, edges, rep_set, tick_vec;
    logic [NUM_MOVES-1:0] pend_q, pend_d, ack_mask;
    logic [ISSUED_W-1:0]  issued_q, issued_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 timeout_q, timeout_d;
    logic                 tick, ack_take, grav_clear, any_pend, enter_issue;

    assign btn_now    = {btn_right, btn_left, btn_down, btn_ccw, btn_cw};
    assign edges      = btn_now & ~btn_prev_q;
    assign tick_vec   = {2'b00, tick, 2'b00};
    assign ack_take   = (state_q == ST_ISSUE) && move_ack && !game_over;
    assign ack_mask   = NUM_MOVES'(1) << cmd_q;
    assign grav_clear = ack_take && (cmd_q == MOVE_DOWN);

    gravity_timer #(
        .PERIOD_V0 (PERIOD_V0),
        .PERIOD_V1 (PERIOD_V1),
        .PERIOD_V2 (PERIOD_V2),
        .PERIOD_V3 (PERIOD_V3)
    ) u_gravity (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .velocity    (velocity),
        .clear       (grav_clear),
        .freeze      (game_over),
        .tick        (tick)
    );

`ifdef AUTO_REPEAT_EN
    // Only down/left/right repeat; a repeat is armed by a real edge seen outside game_over.
    assign rep_set[1:0] = '0;
    for (genvar i = 2; i < NUM_MOVES; i++) begin : g_repeat
        logic [REPEAT_W-1:0] rep_cnt_q;
        logic                rep_arm_q;
        logic                rep_fire_q;

        always_ff @(posedge clk) begin
            if (reset || game_over) begin
                rep_cnt_q  <= '0;
                rep_arm_q  <= 1'b0;
                rep_fire_q <= 1'b0;
            end else begin
                rep_fire_q <= 1'b0;
                if (edges[i]) begin
                    rep_cnt_q <= '0;
                    rep_arm_q <= 1'b1;
                end else if (!btn_now[i]) begin
                    rep_arm_q <= 1'b0;
                end else if (rep_arm_q && frame_start) begin
                    if (rep_cnt_q == REPEAT_W'(DAS_FRAMES - 1)) begin
                        rep_fire_q <= 1'b1;
                        rep_cnt_q  <= REPEAT_W'(DAS_FRAMES - ARR_FRAMES);
                    end else begin
                        rep_cnt_q <= rep_cnt_q + REPEAT_W'(1);
                    end
                end
            end
        end

        assign rep_set[i] = rep_fire_q;
    end
`else
    assign rep_set = '0;
`endif

    // New requests merge into pending bits before the ack clears the served one.
    always_comb begin
        pend_d = pend_q | edges | rep_set | tick_vec;
        if (ack_take)  pend_d = pend_d & ~ack_mask;
        if (game_over) pend_d = '0;
    end

    assign winner   = pick_winner(pend_d);
    assign any_pend = |pend_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start && any_pend) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (move_ack)                                   state_d = ST_NEXT;
                else if (wait_q == WAIT_W'(ACK_TIMEOUT - 1))    state_d = ST_IDLE;
            end
            ST_NEXT: begin
                if (any_pend && (issued_q < ISSUED_W'(MAX_PER_FRAME))) state_d = ST_ISSUE;
                else                                                   state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (game_over) state_d = ST_IDLE;
    end

    assign enter_issue = (state_q != ST_ISSUE) && (state_d == ST_ISSUE);

    always_comb begin
        cmd_d     = cmd_q;
        issued_d  = issued_q;
        wait_d    = '0;
        timeout_d = 1'b0;
        if (enter_issue) cmd_d = winner;
        if ((state_q == ST_IDLE) && enter_issue) issued_d = '0;
        if (ack_take) issued_d = issued_q + ISSUED_W'(1);
        if ((state_q == ST_ISSUE) && (state_d == ST_ISSUE)) wait_d = wait_q + WAIT_W'(1);
        timeout_d = (state_q == ST_ISSUE) && !move_ack && !game_over
                    && (wait_q == WAIT_W'(ACK_TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev_q <= '0;
            pend_q     <= '0;
            cmd_q      <= MOVE_NONE;
            issued_q   <= '0;
            wait_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            btn_prev_q <= btn_now;
            pend_q     <= pend_d;
            cmd_q      <= cmd_d;
            issued_q   <= issued_d;
            wait_q     <= wait_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        move_valid  = (state_q == ST_ISSUE);
        move_cmd    = (state_q == ST_ISSUE) ? cmd_q : MOVE_NONE;
        timeout_err = timeout_q;
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: gravity, priority, per-frame cap, ack timeout,
// game_over freeze, reset mid-handshake and (with AUTO_REPEAT_EN) hold-to-repeat.
module tb_move_scheduler;
    import tetris_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_cw, btn_ccw, btn_left, btn_right, btn_down;
    logic [1:0] velocity;
    logic       frame_start, game_over, move_ack;
    logic       move_valid;
    logic [2:0] move_cmd;
    logic       timeout_err;

    int checks   = 0;
    int failures = 0;
    int nv, nt;
    logic exp_v;

    always #5 clk = ~clk;

    move_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .btn_cw      (btn_cw),
        .btn_ccw     (btn_ccw),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_down    (btn_down),
        .velocity    (velocity),
        .frame_start (frame_start),
        .game_over   (game_over),
        .move_ack    (move_ack),
        .move_valid  (move_valid),
        .move_cmd    (move_cmd),
        .timeout_err (timeout_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        btn_cw = 0; btn_ccw = 0; btn_left = 0; btn_right = 0; btn_down = 0;
        frame_start = 0; game_over = 0; move_ack = 0;
        reset = 1'b1;
        idle(3);
        check_eq("rst_vld", move_valid, 0);
        check_eq("rst_cmd", move_cmd, 3'b101);
        check_eq("rst_terr", timeout_err, 0);
        reset = 1'b0;
        step();
    endtask

    // Expects an offered command, holds ack off one cycle, then acks it.
    task automatic ack_cmd(input logic [2:0] exp_cmd, input string tag);
        check_eq({tag, "_vld"}, move_valid, 1);
        check_eq({tag, "_cmd"}, move_cmd, exp_cmd);
        step();
        check_eq({tag, "_hold"}, move_cmd, exp_cmd);
        move_ack = 1'b1;
        step();
        move_ack = 1'b0;
        check_eq({tag, "_gap"}, move_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        velocity = 2'b11;
        do_reset();

        // Gravity alone at the fastest speed: a down every 6th frame.
        for (int f = 1; f <= 100; f++) begin
            do_frame();
            exp_v = ((f % 6) == 0);
            check_eq($sformatf("t1_f%0d_vld", f), move_valid, exp_v);
            check_eq($sformatf("t1_f%0d_cmd", f), move_cmd, exp_v ? 3'b010 : 3'b101);
            if (exp_v) begin
                move_ack = 1'b1; step(); move_ack = 1'b0;
            end
            idle(3);
        end

        // Priority and per-frame cap.
        velocity = 2'b00;
        do_reset();
        btn_cw = 1; btn_left = 1; step(); btn_cw = 0; btn_left = 0; step();
        do_frame();
        ack_cmd(3'b000, "t2_cw");
        step();
        ack_cmd(3'b011, "t2_left");
        step();
        check_eq("t2_idle", move_valid, 0);
        btn_ccw = 1; btn_right = 1; btn_down = 1; step();
        btn_ccw = 0; btn_right = 0; btn_down = 0; step();
        do_frame();
        ack_cmd(3'b001, "t2_ccw");
        step();
        ack_cmd(3'b100, "t2_right");
        step();
        check_eq("t2_cap", move_valid, 0);
        idle(2);
        check_eq("t2_cap_hold", move_valid, 0);
        do_frame();
        ack_cmd(3'b010, "t2_down_next");
        step();
        check_eq("t2_end", move_valid, 0);

        // Slowest gravity, soft drop restarting the count, velocity change.
        do_reset();
        for (int f = 1; f <= 48; f++) begin
            do_frame();
            exp_v = (f == 48);
            check_eq($sformatf("t3a_f%0d_vld", f), move_valid, exp_v);
            if (exp_v) ack_cmd(3'b010, "t3a_grav");
            idle(3);
        end
        for (int f = 1; f <= 68; f++) begin
            if (f == 20) begin
                btn_down = 1; step(); btn_down = 0;
            end
            do_frame();
            exp_v = (f == 20) || (f == 68);
            check_eq($sformatf("t3b_f%0d_vld", f), move_valid, exp_v);
            if (exp_v) ack_cmd(3'b010, $sformatf("t3b_f%0d", f));
            idle(3);
        end
        for (int f = 1; f <= 10; f++) begin
            do_frame();
            check_eq($sformatf("t3c_f%0d_vld", f), move_valid, 0);
            idle(2);
        end
        velocity = 2'b11;
        do_frame();
        ack_cmd(3'b010, "t3c_velchg");
        velocity = 2'b00;
        idle(2);

        // Ack timeout and re-offer.
        do_reset();
        btn_ccw = 1; step(); btn_ccw = 0;
        do_frame();
        nv = 0; nt = 0;
        for (int i = 0; i < 80; i++) begin
            if (move_valid)  nv++;
            if (timeout_err) nt++;
            step();
        end
        check_eq("t4_valid_cycles", nv, 64);
        check_eq("t4_terr_pulses", nt, 1);
        check_eq("t4_idle", move_valid, 0);
        do_frame();
        ack_cmd(3'b001, "t4_reoffer");
        idle(2);

        // game_over freeze and held buttons afterwards.
        do_reset();
        btn_right = 1; step();
        do_frame();
        check_eq("t5_offer_vld", move_valid, 1);
        check_eq("t5_offer_cmd", move_cmd, 3'b100);
        game_over = 1; step();
        check_eq("t5_go_vld", move_valid, 0);
        check_eq("t5_go_cmd", move_cmd, 3'b101);
        do_frame();
        check_eq("t5_go_frame", move_valid, 0);
        idle(2);
        game_over = 0; step();
        for (int f = 1; f <= 3; f++) begin
            do_frame();
            check_eq($sformatf("t5_held_f%0d", f), move_valid, 0);
            idle(2);
        end
        btn_right = 0; step(); btn_right = 1; step();
        do_frame();
        ack_cmd(3'b100, "t5_repress");
        btn_right = 0;
        idle(2);

        // Reset mid-handshake drops the command; ack outside ISSUE is ignored.
        do_reset();
        btn_cw = 1; step(); btn_cw = 0;
        do_frame();
        check_eq("t6_pre_vld", move_valid, 1);
        reset = 1; step(); reset = 0;
        check_eq("t6_rst_vld", move_valid, 0);
        check_eq("t6_rst_cmd", move_cmd, 3'b101);
        check_eq("t6_rst_terr", timeout_err, 0);
        step();
        do_frame();
        check_eq("t6_dropped", move_valid, 0);
        idle(2);
        btn_cw = 1; step(); btn_cw = 0;
        move_ack = 1; idle(2); move_ack = 0;
        do_frame();
        ack_cmd(3'b000, "t6_ack_ignored");
        idle(2);

`ifdef AUTO_REPEAT_EN
        // Hold left: commands on window-relative frames 1, 11, 14, 17, 20.
        do_reset();
        btn_left = 1; step();
        nv = 0;
        for (int f = 1; f <= 20; f++) begin
            do_frame();
            exp_v = (f == 1) || (f == 11) || (f == 14) || (f == 17) || (f == 20);
            check_eq($sformatf("t7_f%0d_vld", f), move_valid, exp_v);
            if (move_valid) nv++;
            if (exp_v) ack_cmd(3'b011, $sformatf("t7_f%0d", f));
            idle(3);
        end
        check_eq("t7_count", nv, 5);
        btn_left = 0;
        idle(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
